// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: data width, bit counter width and FSM states.
package fifo_uart_tx_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned BIT_CNT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses tick on the last count and pre_tick_c one count earlier.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_cnt;

    assign tick       = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_tick_c = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and serialises each as a UART 8N1/8N2 frame, LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_ready,
    input  logic [UART_DATA_W-1:0] fifo_data,
    output logic                   fifo_rd,
    output logic                   tx,
    output logic                   busy,
    output logic                   byte_done
);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(UART_DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    state_t                 r_state;
    logic [UART_DATA_W-1:0] r_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   w_tick;
    logic                   w_pre_tick;
    logic                   w_clr;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_clr),
        .tick       (w_tick),
        .pre_tick_c (w_pre_tick)
    );

    // Restart the bit period whenever the FSM is about to change state.
    always_comb begin
        w_clr = 1'b0;
        case (r_state)
            ST_IDLE:          w_clr = enable & fifo_ready;
            ST_REQ, ST_LOAD:  w_clr = 1'b1;
            ST_START:         w_clr = w_tick;
            ST_DATA:          w_clr = w_tick && (r_bit_cnt == LAST_DATA);
            ST_STOP:          w_clr = w_tick && (r_bit_cnt == LAST_STOP);
            default:          w_clr = 1'b1;
        endcase
    end

    // Outputs are loaded with the value belonging to the cycle that follows each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            fifo_rd   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            fifo_rd   <= 1'b0;
            byte_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && fifo_ready) begin
                        r_state <= ST_REQ;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_state   <= ST_LOAD;
                    r_bit_cnt <= '0;
                end
                ST_LOAD: begin
                    r_state <= ST_START;
                    r_shift <= fifo_data;
                    tx      <= 1'b0;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        tx      <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == LAST_DATA) begin
                            r_state <= ST_STOP;
                            tx      <= 1'b1;
                        end else begin
                            tx      <= r_shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_pre_tick && (r_bit_cnt == LAST_STOP)) begin
                        byte_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_STOP) begin
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= '0;
                            busy      <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: behavioural FIFOs feed a 1-stop and a 2-stop instance.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic            clk = 1'b0;
    logic [1:0]      rst;
    logic [1:0]      enable;
    logic [1:0]      fifo_ready;
    logic [1:0][7:0] fifo_data;
    logic [1:0]      fifo_rd;
    logic [1:0]      tx;
    logic [1:0]      busy;
    logic [1:0]      byte_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural FIFO per instance: byte appears on fifo_data the cycle after fifo_rd.
    logic [7:0] mem [2][16];
    int         wr_ptr [2] = '{0, 0};
    int         rd_ptr [2] = '{0, 0};
    int         n_underflow = 0;

    assign fifo_ready[0] = (wr_ptr[0] != rd_ptr[0]);
    assign fifo_ready[1] = (wr_ptr[1] != rd_ptr[1]);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fifo_rd[d]) begin
                if (wr_ptr[d] == rd_ptr[d]) n_underflow <= n_underflow + 1;
                fifo_data[d] <= mem[d][rd_ptr[d] % 16];
                rd_ptr[d]    <= rd_ptr[d] + 1;
            end
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .enable(enable[0]), .fifo_ready(fifo_ready[0]),
        .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]),
        .byte_done(byte_done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst[1]), .enable(enable[1]), .fifo_ready(fifo_ready[1]),
        .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]),
        .byte_done(byte_done[1])
    );

    task automatic push(input int d, input logic [7:0] b);
        mem[d][wr_ptr[d] % 16] = b;
        wr_ptr[d] = wr_ptr[d] + 1;
    endtask

    // Waits for the start bit, then checks every cycle of the frame against the ideal 8N(sb) waveform.
    // drop_at / rst_at (frame cycle index, -1 = never) inject enable drop or a reset mid-frame.
    task automatic run_frame(input int d, input logic [7:0] b, input int sb, input string name,
                             input int drop_at, input int rst_at, output int gap);
        int   waited;
        int   len;
        int   idx;
        logic exp_tx;
        logic exp_bd;
        gap    = -1;
        waited = 0;
        @(negedge clk);
        while (tx[d] !== 1'b0 && waited < 60) begin
            waited++;
            @(negedge clk);
        end
        n_tests++;
        if (tx[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_bit: tx=%b after %0d cycles, required 0", name, tx[d], waited);
            return;
        end
        gap = waited;
        len = (9 + sb) * CPB;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            idx    = i / CPB;
            exp_tx = (idx == 0) ? 1'b0 : ((idx <= 8) ? b[idx-1] : 1'b1);
            exp_bd = (i == len - 1);
            n_tests++;
            if (tx[d] !== exp_tx) begin
                n_fail++;
                $display("FAIL %s tx cycle %0d: got %b, required %b", name, i, tx[d], exp_tx);
            end
            n_tests++;
            if (byte_done[d] !== exp_bd) begin
                n_fail++;
                $display("FAIL %s byte_done cycle %0d: got %b, required %b", name, i, byte_done[d], exp_bd);
            end
            n_tests++;
            if (busy[d] !== 1'b1 || fifo_rd[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/rd cycle %0d: got %b/%b, required 1/0", name, i, busy[d], fifo_rd[d]);
            end
            if (i == drop_at) enable[d] = 1'b0;
            if (i == rst_at) begin
                rst[d] = 1'b1;
                @(negedge clk);
                n_tests++;
                if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || byte_done[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s after_rst tx/busy/done: got %b/%b/%b, required 1/0/0",
                             name, tx[d], busy[d], byte_done[d]);
                end
                rst[d] = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 2'b11;
        enable = 2'b00;
        push(0, 8'hC5);
        enable[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (tx[0] !== 1'b1 || fifo_rd[0] !== 1'b0 || busy[0] !== 1'b0 || byte_done[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset tx/rd/busy/done: got %b/%b/%b/%b, required 1/0/0/0",
                         tx[0], fifo_rd[0], busy[0], byte_done[0]);
            end
        end
        enable[0] = 1'b0;
        rst[0]    = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_ptr[0] != 0) begin
            n_fail++;
            $display("FAIL reset_release tx/busy/pops: got %b/%b/%0d, required 1/0/0", tx[0], busy[0], rd_ptr[0]);
        end
    endtask

    task automatic test_single_byte();
        int gap;
        enable[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (fifo_rd[0] !== 1'b1 || busy[0] !== 1'b1 || tx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single req rd/busy/tx: got %b/%b/%b, required 1/1/1", fifo_rd[0], busy[0], tx[0]);
        end
        @(negedge clk);
        n_tests++;
        if (fifo_rd[0] !== 1'b0 || busy[0] !== 1'b1 || tx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single load rd/busy/tx: got %b/%b/%b, required 0/1/1", fifo_rd[0], busy[0], tx[0]);
        end
        run_frame(0, 8'hC5, 1, "single", -1, -1, gap);
        n_tests++;
        if (gap != 0) begin
            n_fail++;
            $display("FAIL single tx_fall_latency: got %0d extra cycles, required 0", gap);
        end
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b0 || tx[0] !== 1'b1 || rd_ptr[0] != 1) begin
            n_fail++;
            $display("FAIL single idle busy/tx/pops: got %b/%b/%0d, required 0/1/1", busy[0], tx[0], rd_ptr[0]);
        end
    endtask

    task automatic test_back_to_back(input string name, input int n, input logic rand_bytes);
        logic [7:0] bytes [$];
        logic [7:0] b;
        int         base;
        int         gap;
        enable[0] = 1'b0;
        base = rd_ptr[0];
        for (int k = 0; k < n; k++) begin
            b = rand_bytes ? 8'($urandom_range(0, 255)) : 8'(8'hC0 + k);
            bytes.push_back(b);
            push(0, b);
        end
        enable[0] = 1'b1;
        for (int k = 0; k < n; k++) begin
            run_frame(0, bytes[k], 1, name, -1, -1, gap);
            n_tests++;
            if (gap != ((k == 0) ? 2 : 3)) begin
                n_fail++;
                $display("FAIL %s gap before frame %0d: got %0d, required %0d", name, k, gap, (k == 0) ? 2 : 3);
            end
        end
        repeat (8) @(negedge clk);
        n_tests++;
        if (rd_ptr[0] - base != n || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pops/tx/busy: got %0d/%b/%b, required %0d/1/0", name, rd_ptr[0] - base, tx[0], busy[0], n);
        end
        enable[0] = 1'b0;
    endtask

    task automatic test_enable_drop(output logic [7:0] left);
        int base;
        int gap;
        left = 8'($urandom_range(0, 255));
        base = rd_ptr[0];
        push(0, 8'hA5);
        push(0, left);
        enable[0] = 1'b1;
        run_frame(0, 8'hA5, 1, "en_drop", 17, -1, gap);
        repeat (20) @(negedge clk);
        n_tests++;
        if (rd_ptr[0] - base != 1 || tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop pops/tx/busy/ready: got %0d/%b/%b/%b, required 1/1/0/1",
                     rd_ptr[0] - base, tx[0], busy[0], fifo_ready[0]);
        end
    endtask

    task automatic test_reset_mid(input logic [7:0] first);
        logic [7:0] nxt;
        int         base;
        int         gap;
        nxt  = 8'($urandom_range(0, 255));
        base = rd_ptr[0];
        push(0, nxt);
        enable[0] = 1'b1;
        run_frame(0, first, 1, "rst_mid", -1, 25, gap);
        run_frame(0, nxt, 1, "after_rst", -1, -1, gap);
        n_tests++;
        if (gap != 2) begin
            n_fail++;
            $display("FAIL after_rst gap: got %0d, required 2", gap);
        end
        @(negedge clk);
        n_tests++;
        if (rd_ptr[0] - base != 2 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid pops/busy: got %0d/%b, required 2/0", rd_ptr[0] - base, busy[0]);
        end
        enable[0] = 1'b0;
    endtask

    task automatic test_two_stop();
        logic [7:0] b2;
        int         gap;
        b2 = 8'($urandom_range(0, 255));
        rst[1] = 1'b0;
        push(1, 8'hFF);
        push(1, b2);
        enable[1] = 1'b1;
        run_frame(1, 8'hFF, 2, "stop2_ff", -1, -1, gap);
        run_frame(1, b2, 2, "stop2_rand", -1, -1, gap);
        n_tests++;
        if (gap != 3) begin
            n_fail++;
            $display("FAIL stop2 gap: got %0d, required 3", gap);
        end
        @(negedge clk);
        n_tests++;
        if (rd_ptr[1] != 2 || busy[1] !== 1'b0 || tx[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stop2 pops/busy/tx: got %0d/%b/%b, required 2/0/1", rd_ptr[1], busy[1], tx[1]);
        end
        enable[1] = 1'b0;
    endtask

    initial begin
        logic [7:0] left;
        test_reset();
        test_single_byte();
        test_back_to_back("b2b", 3, 1'b0);
        test_enable_drop(left);
        test_reset_mid(left);
        test_back_to_back("rand", 4, 1'b1);
        test_two_stop();
        n_tests++;
        if (n_underflow != 0) begin
            n_fail++;
            $display("FAIL underflow: got %0d reads of empty FIFO, required 0", n_underflow);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
